seq_signmag_divider: RTL and testbench

//   Sequential sign-magnitude divider; the inverse of the 4x4 sign-magnitude multiply operation.

---
 rtl/seq_signmag_divider_pkg.sv | 23 ++
 rtl/signmag_div_core.sv | 62 ++++++
 rtl/seq_signmag_divider.sv | 136 +++++++++++++
 tb/tb_seq_signmag_divider.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seq_signmag_divider_pkg.sv
// Shared types and constants for the sign-magnitude divider: FSM states,
// default widths, sign-bit helper and 7-segment glyphs.
package seq_signmag_divider_pkg;

    localparam int DIVIDEND_W_DFLT = 8;
    localparam int DIVISOR_W_DFLT  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, active high.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_ERROR = 7'b1111001;

    // Operands are {sign, magnitude}, so the sign sits just above the magnitude.
    function automatic int sign_idx(input int mag_w);
        return mag_w;
    endfunction

endpackage

// File: rtl/signmag_div_core.sv
// Restoring shift/subtract datapath: one quotient bit per step, MSB first,
// with the iteration counter that flags the final step.
module signmag_div_core #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [DIVISOR_W-1:0]  i_divisor,
    output logic                  o_last,
    output logic [DIVIDEND_W-1:0] o_quot_nxt,
    output logic [DIVISOR_W-1:0]  o_rem_nxt
);

    localparam int CW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    logic [DIVIDEND_W-1:0] r_dvd;
    logic [DIVISOR_W-1:0]  r_div;
    logic [DIVISOR_W-1:0]  r_part;
    logic [DIVIDEND_W-1:0] r_quot;
    logic [CW-1:0]         r_cnt;

    logic [DIVISOR_W:0]    w_shift;
    logic                  w_ge;
    logic [DIVISOR_W-1:0]  w_diff;
    logic [DIVISOR_W-1:0]  w_part_nxt;

    // The partial stays below the divisor, so after the subtract it fits in DIVISOR_W bits.
    assign w_shift    = {r_part, r_dvd[DIVIDEND_W-1]};
    assign w_ge       = (w_shift >= {1'b0, r_div});
    assign w_diff     = w_shift[DIVISOR_W-1:0] - r_div;
    assign w_part_nxt = w_ge ? w_diff : w_shift[DIVISOR_W-1:0];

    assign o_quot_nxt = {r_quot[DIVIDEND_W-2:0], w_ge};
    assign o_rem_nxt  = w_part_nxt;
    assign o_last     = (r_cnt == CW'(DIVIDEND_W - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dvd  <= '0;
            r_div  <= '0;
            r_part <= '0;
            r_quot <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_dvd  <= i_dividend;
            r_div  <= i_divisor;
            r_part <= '0;
            r_quot <= '0;
            r_cnt  <= '0;
        end else if (i_step) begin
            r_dvd  <= {r_dvd[DIVIDEND_W-2:0], 1'b0};
            r_part <= w_part_nxt;
            r_quot <= o_quot_nxt;
            r_cnt  <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seq_signmag_divider.sv
// Sequential sign-magnitude divider top: FSM, sign handling and result registers.
// Optional display decode is enabled with `define DIVIDER_DISPLAY_EN.
module seq_signmag_divider
    import seq_signmag_divider_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DFLT,
    parameter int DIVISOR_W  = DIVISOR_W_DFLT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DIVIDEND_W:0]   dividend,
    input  logic [DIVISOR_W:0]    divisor,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic                  q_sign,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  r_sign,
    output logic [1:0]            dbg_state
`ifdef DIVIDER_DISPLAY_EN
    ,
    output logic [6:0]            display0,
    output logic [6:0]            display1,
    output logic [6:0]            display2,
    output logic [6:0]            display3,
    output logic [6:0]            display4,
    output logic [6:0]            display5
`endif
);

    // Handshake: start is taken only when sampled high in IDLE; any other start
    // is dropped. done is a single-cycle pulse and results stay valid until the next accept.
    state_t r_state;
    state_t w_state_nxt;

    logic                  r_a_sign;
    logic                  r_b_sign;
    logic                  r_div_zero;
    logic [DIVIDEND_W-1:0] r_quot;
    logic                  r_qs;
    logic [DIVISOR_W-1:0]  r_rem;
    logic                  r_rs;

    logic                  w_accept;
    logic                  w_b_zero;
    logic                  w_calc;
    logic                  w_last;
    logic [DIVIDEND_W-1:0] w_quot_nxt;
    logic [DIVISOR_W-1:0]  w_rem_nxt;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_b_zero = (divisor[DIVISOR_W-1:0] == '0);
    assign w_calc   = (r_state == ST_CALC);

    signmag_div_core #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (DIVISOR_W)
    ) u_core (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_accept),
        .i_step     (w_calc),
        .i_dividend (dividend[DIVIDEND_W-1:0]),
        .i_divisor  (divisor[DIVISOR_W-1:0]),
        .o_last     (w_last),
        .o_quot_nxt (w_quot_nxt),
        .o_rem_nxt  (w_rem_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = w_b_zero ? ST_DONE : ST_CALC;
            ST_CALC: if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_CALC);
        done = (r_state == ST_DONE);
    end

    // Results are written on the final iteration so they never move during CALC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_sign   <= 1'b0;
            r_b_sign   <= 1'b0;
            r_div_zero <= 1'b0;
            r_quot     <= '0;
            r_qs       <= 1'b0;
            r_rem      <= '0;
            r_rs       <= 1'b0;
        end else if (w_accept) begin
            r_a_sign   <= dividend[sign_idx(DIVIDEND_W)];
            r_b_sign   <= divisor[sign_idx(DIVISOR_W)];
            r_div_zero <= w_b_zero;
            if (w_b_zero) begin
                r_quot <= '1;
                r_rem  <= '0;
                r_qs   <= 1'b0;
                r_rs   <= 1'b0;
            end
        end else if (w_calc && w_last) begin
            r_quot <= w_quot_nxt;
            r_rem  <= w_rem_nxt;
            r_qs   <= (r_a_sign ^ r_b_sign) && (w_quot_nxt != '0);
            r_rs   <= r_a_sign && (w_rem_nxt != '0);
        end
    end

    assign div_zero  = r_div_zero;
    assign quotient  = r_quot;
    assign q_sign    = r_qs;
    assign remainder = r_rem;
    assign r_sign    = r_rs;
    assign dbg_state = r_state;

`ifdef DIVIDER_DISPLAY_EN
    BinaryTo7Segment u_seg0 (.i_bin(r_quot[3:0]), .o_seg(display0));
    BinaryTo7Segment u_seg1 (.i_bin(r_quot[7:4]), .o_seg(display1));
    BinaryTo7Segment u_seg2 (.i_bin(r_rem[3:0]),  .o_seg(display2));
    SignDisplay      u_sgn3 (.i_sign(r_qs),       .o_seg(display3));
    SignDisplay      u_sgn4 (.i_sign(r_rs),       .o_seg(display4));
    assign display5 = r_div_zero ? SEG_ERROR : SEG_BLANK;
`endif

endmodule

// File: tb/tb_seq_signmag_divider.sv
// Self-checking bench for seq_signmag_divider: directed cases plus random
// operands against an arithmetic reference model.
module tb_seq_signmag_divider;
    import seq_signmag_divider_pkg::*;

    localparam int DW = 8;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [DW:0]   dividend;
    logic [VW:0]   divisor;
    logic          busy;
    logic          done;
    logic          div_zero;
    logic [DW-1:0] quotient;
    logic          q_sign;
    logic [VW-1:0] remainder;
    logic          r_sign;
    logic [1:0]    dbg_state;

    seq_signmag_divider dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .quotient  (quotient),
        .q_sign    (q_sign),
        .remainder (remainder),
        .r_sign    (r_sign),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // scoreboard: {div_zero, q_sign, quotient, r_sign, remainder}
    logic [14:0] exp_q[$];
    logic [14:0] last_exp;
    bit          chk_pulse = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Truncating signed division on magnitudes, no negative zero.
    function automatic logic [14:0] model(input logic sa, input logic [7:0] ma,
                                          input logic sb, input logic [3:0] mb);
        int q;
        int r;
        if (mb == 0) return {1'b1, 1'b0, 8'hFF, 1'b0, 4'h0};
        q = int'(ma) / int'(mb);
        r = int'(ma) % int'(mb);
        return {1'b0, (sa ^ sb) && (q != 0), 8'(q), sa && (r != 0), 4'(r)};
    endfunction

    function automatic logic [14:0] observed();
        return {div_zero, q_sign, quotient, r_sign, remainder};
    endfunction

    // driver: one division, with optional extra start pulses in CALC cycles g1/g2
    task automatic run_div(input logic sa, input logic [7:0] ma, input logic sb,
                           input logic [3:0] mb, input int g1, input int g2);
        int          cnt;
        logic [7:0]  held_q;
        logic [14:0] exp;
        @(negedge clk);
        if (chk_pulse) begin
            check("done_pulse", done, 1'b0);
            check("held_results", observed(), last_exp);
        end
        held_q   = quotient;
        dividend = {sa, ma};
        divisor  = {sb, mb};
        start    = 1'b1;
        exp_q.push_back(model(sa, ma, sb, mb));
        @(posedge clk);
        cnt = 0;
        while (1) begin
            @(negedge clk);
            if (cnt == g1 - 1 || cnt == g2 - 1) begin
                start    = 1'b1;
                dividend = 9'($urandom);
                divisor  = 5'($urandom);
            end else begin
                start = 1'b0;
            end
            if (done || cnt >= 30) break;
            if (cnt == 0) begin
                check("busy", busy, 1'b1);
                check("dz_clear", div_zero, 1'b0);
            end
            if (cnt == 3) check("hold_q", quotient, held_q);
            @(posedge clk);
            cnt++;
        end
        start = 1'b0;
        check("latency", cnt + 1, (mb == 0) ? 1 : DW + 1);
        exp = exp_q.pop_front();
        check("result", observed(), exp);
        check("busy_in_done", busy, 1'b0);
        if (mb != 0) check("invariant", int'(quotient) * int'(mb) + int'(remainder), ma);
        last_exp  = exp;
        chk_pulse = 1'b1;
    endtask

    task automatic reset_mid();
        int n_done;
        @(negedge clk);
        dividend = {1'b1, 8'd200};
        divisor  = {1'b0, 4'd3};
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_outs", observed(), 15'h0);
        check("rst_mid_state", dbg_state, ST_IDLE);
        @(negedge clk);
        reset_n = 1'b1;
        n_done  = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("no_done_after_rst", n_done, 0);
        chk_pulse = 1'b0;
    endtask

    initial begin
        int n_done;
        logic [3:0] mb;
        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_outs", observed(), 15'h0);
        check("rst_state", dbg_state, ST_IDLE);
        reset_n = 1'b1;

        run_div(1'b0, 8'd100, 1'b0, 4'd7, 0, 0);
        run_div(1'b1, 8'd100, 1'b0, 4'd7, 0, 0);
        run_div(1'b0, 8'd100, 1'b1, 4'd7, 0, 0);
        run_div(1'b0, 8'd3,   1'b0, 4'd9, 0, 0);
        run_div(1'b1, 8'd0,   1'b1, 4'd5, 0, 0);
        run_div(1'b0, 8'd255, 1'b0, 4'd0, 0, 0);
        run_div(1'b0, 8'd100, 1'b0, 4'd7, 0, 0);
        run_div(1'b1, 8'd77,  1'b0, 4'd5, 3, 8);

        n_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("no_queued_op", n_done, 0);
        chk_pulse = 1'b0;

        reset_mid();
        run_div(1'b0, 8'd100, 1'b0, 4'd7, 0, 0);

        for (int i = 0; i < 40; i++) begin
            mb = 4'($urandom_range(0, 15));
            run_div(1'($urandom), 8'($urandom), 1'($urandom), mb, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
